// File: rtl/fifo_arb_pkg.sv
// Shared types and default constants for the FIFO write arbiter.
// State encoding is fixed: IDLE = 0, BURST = 1.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_NUM_REQ    = 4;
    localparam int unsigned DEF_MAX_BURST  = 4;

    // Index width that stays at least one bit wide for degenerate counts.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned wrap_add(input int unsigned base,
                                             input int unsigned off,
                                             input int unsigned n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin first-one search: returns the first set request at or after
// ptr (wrapping modulo N) and whether any request was set at all.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int unsigned N     = DEF_NUM_REQ,
    parameter int unsigned IDX_W = idx_width(DEF_NUM_REQ)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = IDX_W'(wrap_add(32'(ptr), i, N));
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter merging NUM_REQ valid/ready requesters into one
// shared FIFO write port, up to MAX_BURST beats per grant.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
    parameter int unsigned MAX_BURST  = DEF_MAX_BURST
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          wr,
    output logic [DATA_WIDTH-1:0]         wr_data,
    input  logic                          full,
    output logic                          busy
);

    localparam int unsigned      IDX_W     = idx_width(NUM_REQ);
    localparam int unsigned      CNT_W     = idx_width(MAX_BURST);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    arb_state_t            state, state_nxt;
    logic [IDX_W-1:0]      owner, owner_nxt;
    logic [IDX_W-1:0]      rr_ptr, rr_ptr_nxt;
    logic [CNT_W-1:0]      beat_cnt, beat_cnt_nxt;
    logic [IDX_W-1:0]      owner_inc;
    logic [IDX_W-1:0]      pick_ptr;
    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_found;
    logic                  owner_valid;
    logic                  grant_end;
    logic [DATA_WIDTH-1:0] owner_data;

    assign owner_valid = req_valid[owner];
    assign owner_inc   = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

    // At grant end the search already starts past the current owner, so the
    // next owner can be registered in the same cycle without an IDLE bubble.
    assign pick_ptr  = (state == BURST) ? owner_inc : rr_ptr;
    assign grant_end = (state == BURST) &&
                       (!owner_valid || (wr && (beat_cnt == LAST_BEAT)));

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (req_valid),
        .ptr   (pick_ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_comb begin
        owner_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (owner == IDX_W'(i)) begin
                owner_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        grant     = '0;
        req_ready = '0;
        wr        = 1'b0;
        wr_data   = '0;
        busy      = 1'b0;
        if (state == BURST) begin
            busy             = 1'b1;
            grant[owner]     = 1'b1;
            req_ready[owner] = ~full;
            wr               = owner_valid & ~full;
            wr_data          = owner_data;
        end
    end

    always_comb begin
        state_nxt    = state;
        owner_nxt    = owner;
        rr_ptr_nxt   = rr_ptr;
        beat_cnt_nxt = beat_cnt;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_nxt    = BURST;
                    owner_nxt    = pick_idx;
                    beat_cnt_nxt = '0;
                end
            end
            BURST: begin
                if (grant_end) begin
                    rr_ptr_nxt   = owner_inc;
                    beat_cnt_nxt = '0;
                    if (pick_found) begin
                        owner_nxt = pick_idx;
                    end else begin
                        state_nxt = IDLE;
                        owner_nxt = '0;
                    end
                end else if (wr) begin
                    beat_cnt_nxt = beat_cnt + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            rr_ptr   <= rr_ptr_nxt;
            beat_cnt <= beat_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: queue-driven requesters, a
// behavioural arbitration model checked every cycle, plus directed scenarios.
module tb_fifo_wr_arbiter;

    localparam int DW = 8;
    localparam int NR = 4;
    localparam int MB = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              full = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR*DW-1:0]  req_data = '0;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     grant;
    logic              wr;
    logic [DW-1:0]     wr_data;
    logic              busy;

    fifo_wr_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR),
        .MAX_BURST  (MB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .grant     (grant),
        .wr        (wr),
        .wr_data   (wr_data),
        .full      (full),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Requester source queues (array + head/tail) and enable flags.
    logic [DW-1:0] src [NR][32];
    int            hd [NR];
    int            tl [NR];
    bit            en [NR];

    // Model: current owner (-1 when idle), beats taken this grant, pointer.
    int m_owner = -1;
    int m_beats = 0;
    int m_ptr   = 0;

    // Log of writes observed on the DUT port.
    int            log_own [64];
    logic [DW-1:0] log_dat [64];
    int            log_n = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [NR-1:0] v, input int from);
        for (int k = 0; k < NR; k++) begin
            if (v[(from + k) % NR]) return (from + k) % NR;
        end
        return -1;
    endfunction

    function automatic int oh2idx(input logic [NR-1:0] v);
        for (int k = 0; k < NR; k++) begin
            if (v[k]) return k;
        end
        return -1;
    endfunction

    task automatic apply_inputs();
        for (int i = 0; i < NR; i++) begin
            req_valid[i]         = en[i] && (hd[i] < tl[i]);
            req_data[i*DW +: DW] = (hd[i] < tl[i]) ? src[i][hd[i]] : '0;
        end
    endtask

    task automatic load(input int r, input logic [DW-1:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            src[r][tl[r]] = base + DW'(k);
            tl[r]++;
        end
        en[r] = 1'b1;
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_beats = 0;
        m_ptr   = 0;
    endtask

    // One clock edge of the model, using the inputs the DUT sampled.
    task automatic model_advance();
        bit acc;
        bit fin;
        int p;
        if (!reset) return;
        if (m_owner < 0) begin
            p = pick(req_valid, m_ptr);
            if (p >= 0) begin
                m_owner = p;
                m_beats = 0;
            end
        end else begin
            acc = req_valid[m_owner] && !full;
            fin = !req_valid[m_owner];
            if (acc) begin
                hd[m_owner]++;
                m_beats++;
                if (m_beats == MB) fin = 1'b1;
            end
            if (fin) begin
                m_ptr   = (m_owner + 1) % NR;
                m_owner = pick(req_valid, m_ptr);
                m_beats = 0;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_advance();
        #1;
        apply_inputs();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        full  = 1'b0;
        model_reset();
        for (int i = 0; i < NR; i++) begin
            hd[i] = 0;
            tl[i] = 0;
            en[i] = 1'b0;
        end
        apply_inputs();
        repeat (2) cycle();
        reset = 1'b1;
        log_n = 0;
    endtask

    task automatic run_until_idle(input int max_cycles);
        int c;
        c = 0;
        while (!(m_owner < 0 && req_valid == '0) && c < max_cycles) begin
            cycle();
            c++;
        end
        chk("drain_in_budget", 32'(c < max_cycles), 32'd1);
    endtask

    // Per-cycle compare against the model plus protocol invariants.
    always @(negedge clk) begin
        logic [NR-1:0] eg;
        logic [NR-1:0] er;
        logic          ew;
        logic [DW-1:0] ed;
        eg = '0;
        er = '0;
        ew = 1'b0;
        ed = '0;
        if (m_owner >= 0) begin
            eg[m_owner] = 1'b1;
            er[m_owner] = !full;
            ew          = req_valid[m_owner] && !full;
            ed          = req_data[m_owner*DW +: DW];
        end
        chk("cyc_grant", 32'(grant), 32'(eg));
        chk("cyc_req_ready", 32'(req_ready), 32'(er));
        chk("cyc_wr", 32'(wr), 32'(ew));
        chk("cyc_wr_data", 32'(wr_data), 32'(ed));
        chk("cyc_busy", 32'(busy), 32'(m_owner >= 0));
        chk("inv_wr_full", 32'(wr & full), 32'd0);
        chk("inv_grant_onehot0", 32'($onehot0(grant)), 32'd1);
        chk("inv_ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
        if (wr && log_n < 64) begin
            log_own[log_n] = oh2idx(grant);
            log_dat[log_n] = wr_data;
            log_n++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state while reset is held low.
        #1;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_wr", 32'(wr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // Single requester, six beats: burst of four then re-grant for two.
        do_reset();
        load(0, 8'h10, 6);
        apply_inputs();
        #1;
        chk("t1_sel_grant", 32'(grant), 32'd0);
        chk("t1_sel_wr", 32'(wr), 32'd0);
        cycle();
        chk("t1_grant", 32'(grant), 32'b0001);
        chk("t1_first_wr", 32'(wr), 32'd1);
        chk("t1_first_data", 32'(wr_data), 32'h10);
        run_until_idle(30);
        chk("t1_nwr", 32'(log_n), 32'd6);
        for (int k = 0; k < 6; k++) begin
            chk("t1_data", 32'(log_dat[k]), 32'h10 + 32'(k));
            chk("t1_owner", 32'(log_own[k]), 32'd0);
        end

        // All requesters valid: order 0,1,2,3,0,1,2,3 with four beats each.
        do_reset();
        for (int i = 0; i < NR; i++) load(i, DW'(i * 32), 8);
        apply_inputs();
        run_until_idle(60);
        chk("t2_nwr", 32'(log_n), 32'd32);
        for (int k = 0; k < 32; k++) begin
            chk("t2_owner", 32'(log_own[k]), 32'((k / 4) % 4));
            chk("t2_data", 32'(log_dat[k]), 32'(((k / 4) % 4) * 32 + (k / 16) * 4 + (k % 4)));
        end

        // Requester 2 stalled by full for three cycles mid-burst.
        do_reset();
        load(2, 8'hA0, 4);
        apply_inputs();
        cycle();
        chk("t3_grant", 32'(grant), 32'b0100);
        cycle();
        cycle();
        full = 1'b1;
        #1;
        chk("t3_stall_wr", 32'(wr), 32'd0);
        chk("t3_stall_ready", 32'(req_ready), 32'd0);
        chk("t3_stall_grant", 32'(grant), 32'b0100);
        repeat (3) cycle();
        chk("t3_stall_nwr", 32'(log_n), 32'd2);
        chk("t3_stall_hold", 32'(grant), 32'b0100);
        full = 1'b0;
        run_until_idle(30);
        chk("t3_nwr", 32'(log_n), 32'd4);
        for (int k = 0; k < 4; k++) begin
            chk("t3_data", 32'(log_dat[k]), 32'hA0 + 32'(k));
        end

        // Requester 1 runs dry after two beats while requester 3 waits.
        do_reset();
        load(1, 8'h50, 2);
        apply_inputs();
        cycle();
        chk("t4_grant1", 32'(grant), 32'b0010);
        load(3, 8'h70, 4);
        apply_inputs();
        #1;
        cycle();
        cycle();
        chk("t4_drop_grant", 32'(grant), 32'b0010);
        chk("t4_drop_wr", 32'(wr), 32'd0);
        cycle();
        chk("t4_handoff", 32'(grant), 32'b1000);
        run_until_idle(30);
        chk("t4_nwr", 32'(log_n), 32'd6);
        chk("t4_own0", 32'(log_own[0]), 32'd1);
        chk("t4_own1", 32'(log_own[1]), 32'd1);
        chk("t4_data1", 32'(log_dat[1]), 32'h51);
        for (int k = 2; k < 6; k++) begin
            chk("t4_own3", 32'(log_own[k]), 32'd3);
            chk("t4_data3", 32'(log_dat[k]), 32'h70 + 32'(k - 2));
        end

        // Reset asserted during requester 0 beat 2, then 0110 after release.
        do_reset();
        load(0, 8'hC0, 4);
        apply_inputs();
        cycle();
        cycle();
        chk("t5_mid_wr", 32'(wr), 32'd1);
        chk("t5_mid_data", 32'(wr_data), 32'hC1);
        #1;
        reset = 1'b0;
        model_reset();
        #1;
        chk("t5_rst_grant", 32'(grant), 32'd0);
        chk("t5_rst_ready", 32'(req_ready), 32'd0);
        chk("t5_rst_wr", 32'(wr), 32'd0);
        chk("t5_rst_data", 32'(wr_data), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_nwr", 32'(log_n), 32'd1);
        hd[0] = tl[0];
        en[0] = 1'b0;
        load(1, 8'hD0, 2);
        load(2, 8'hE0, 2);
        apply_inputs();
        cycle();
        cycle();
        reset = 1'b1;
        cycle();
        chk("t5_first_grant", 32'(grant), 32'b0010);
        run_until_idle(30);
        chk("t5_nwr", 32'(log_n), 32'd5);
        chk("t5_own1", 32'(log_own[1]), 32'd1);
        chk("t5_own2", 32'(log_own[2]), 32'd1);
        chk("t5_own3", 32'(log_own[3]), 32'd2);
        chk("t5_own4", 32'(log_own[4]), 32'd2);
        chk("t5_data3", 32'(log_dat[3]), 32'hE0);

        repeat (3) cycle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of each requester data word and of wr_data.
REQ-002 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-003 SHALL have parameter MAX_BURST, default 4, maximum beats per grant (1..16).
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port req_valid  input  NUM_REQ  per-requester data-valid.
REQ-007 SHALL have port req_data  input  NUM_REQ*DATA_WIDTH  packed requester data, requester i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port req_ready  output  NUM_REQ  per-requester accept; beat transfers when req_valid[i] & req_ready[i].
REQ-009 SHALL have port grant  output  NUM_REQ  one-hot current owner, all-zero when idle.
REQ-010 SHALL have port wr  output  1  write strobe to the shared FIFO.
REQ-011 SHALL have port wr_data  output  DATA_WIDTH  write data to the shared FIFO.
REQ-012 SHALL have port full  input  1  shared-FIFO full flag.
REQ-013 SHALL have port busy  output  1  high while in BURST.

Function
REQ-014 SHALL implement two states: IDLE (no owner) and BURST (owner registered).
REQ-015 SHALL, in IDLE with any req_valid set, select the first valid requester scanning upward from rr_ptr modulo NUM_REQ, register it as owner, enter BURST next cycle; no write in the selection cycle (1-cycle arbitration latency).
REQ-016 SHALL, in BURST, drive wr = req_valid[owner] & ~full, req_ready[owner] = ~full, all other req_ready = 0, combinationally.
REQ-017 SHALL drive wr_data = req_data of owner in BURST and hold it at zero in IDLE.
REQ-018 SHALL increment a beat counter on each accepted beat (wr=1) and reset it to 0 at each new grant.
REQ-019 SHALL end the grant when a beat is accepted with beat counter = MAX_BURST-1, or when req_valid[owner]=0 (no write that cycle).
REQ-020 SHALL, at grant end, set rr_ptr = (owner+1) mod NUM_REQ and in the same cycle re-arbitrate from the new rr_ptr; if any req_valid (former owner included, lowest priority) the new owner is granted next cycle without passing through IDLE, else go to IDLE.
REQ-021 SHALL, while full=1, stall: no write, beat counter and owner held, no timeout.
REQ-022 SHALL never assert wr when full=1, and never assert more than one req_ready or grant bit.
REQ-023 SHALL, with MAX_BURST=1, hand off after every accepted beat.

Reset
REQ-024 SHALL, while reset=0, asynchronously force IDLE, rr_ptr=0, beat counter=0, owner cleared, grant=0, req_ready=0, wr=0, wr_data=0, busy=0.
REQ-025 SHALL, on reset assertion mid-burst, abandon the burst; the in-flight beat is not written; first grant after release goes to lowest-index valid requester.

Structure
REQ-026 SHALL place state encoding (IDLE=0, BURST=1) and default parameter constants in shared package fifo_arb_pkg.
REQ-027 SHALL use one sub-module rr_pick (combinational round-robin first-one search from a pointer, returns index and found flag).

Verification
REQ-028 SHALL test: reset, req_valid=4'b0001 with 6 beats 0x10..0x15, full=0 -> grant=0001 one cycle later, writes 0x10..0x13, one-cycle handoff re-grants req0 for 0x14,0x15.
REQ-029 SHALL test: req_valid=4'b1111 held, full=0 -> grant order 0,1,2,3,0, each owner exactly 4 writes per grant.
REQ-030 SHALL test: req2 mid-burst, full=1 for 3 cycles -> wr=0, req_ready=0, beat count held; after full drops, remaining beats complete, total 4 writes.
REQ-031 SHALL test: req1 owner drops req_valid after 2 beats while req3 valid -> grant moves to 1000 next cycle, req1 only 2 writes.
REQ-032 SHALL test: reset pulled low during req0 beat 2 -> all outputs zero immediately; after release with req_valid=4'b0110, first grant = 0010.
REQ-033 SHALL check every cycle: wr implies ~full, grant one-hot or zero, wr_data equals owner data.
